// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
// Error-flag bit indices are also used by the CSR block.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    localparam int ERR_W   = 2;
    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;

    // Ceiling log2 for sizing address fields at elaboration time.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage array: synchronous write, asynchronous read.
// Contents are never reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = clog2(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Store the accepted write word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with level, thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through output.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int AF_LEVEL = 14,
    parameter  int AE_LEVEL = 2,
    localparam int ADDR_W   = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [DATA_W-1:0] data_in,
    input  logic              re,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam logic [ADDR_W:0] LVL_FULL = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] LVL_AF   = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] LVL_AE   = AE_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [ADDR_W:0]    level_w;
    logic               wr_acc;
    logic               rd_acc;
    logic [DATA_W-1:0]  mem_rdata;

    // Occupancy is the modular pointer distance; flags decode it.
    assign level_w      = wr_ptr_q - rd_ptr_q;
    assign full         = (level_w == LVL_FULL);
    assign empty        = (level_w == '0);
    assign almost_full  = (level_w >= LVL_AF);
    assign almost_empty = (level_w <= LVL_AE);
    assign level        = level_w;

    assign wr_acc = we && !full;
    assign rd_acc = re && !empty;

    assign overflow  = err_q[ERR_OVF];
    assign underflow = err_q[ERR_UDF];

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (mem_rdata)
    );

    // Pointer advance and sticky error update; a set beats a same-cycle clear.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (clr_err) begin
            err_d = '0;
        end
        if (we && full) begin
            err_d[ERR_OVF] = 1'b1;
        end
        if (re && empty) begin
            err_d[ERR_UDF] = 1'b1;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN

    // Head word falls through; blank while empty so stale data never shows.
    assign data_out = empty ? '0 : mem_rdata;

`else

    logic [DATA_W-1:0] data_q;

    // Registered read port: capture head word on each accepted read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (rd_acc) begin
            data_q <= mem_rdata;
        end
    end

    assign data_out = data_q;

`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised self-checking bench for sync_fifo_param (default parameters).
// Reference model is a queue of words plus sticky error bits.
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int DP = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mq[$];
    bit            m_ovf;
    bit            m_udf;
    logic [DW-1:0] m_dout;

    sync_fifo_param dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .we           (we),
        .data_in      (data_in),
        .re           (re),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, update model at the edge, compare after it.
    task automatic cyc(input bit r_n, input bit w, input logic [DW-1:0] d,
                       input bit r, input bit c);
        int  n;
        bit  was_full;
        bit  was_empty;
        logic [DW-1:0] exp_d;
        rst_n   = r_n;
        we      = w;
        data_in = d;
        re      = r;
        clr_err = c;
        @(posedge clk);
        if (!r_n) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            m_dout = '0;
        end else begin
            was_full  = (mq.size() == DP);
            was_empty = (mq.size() == 0);
            if (r && !was_empty) begin
                m_dout = mq.pop_front();
            end
            if (w && !was_full) begin
                mq.push_back(d);
            end
            if (c) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (w && was_full) m_ovf = 1'b1;
            if (r && was_empty) m_udf = 1'b1;
        end
        #1;
        n = mq.size();
`ifdef SYNC_FIFO_FWFT_EN
        exp_d = (n == 0) ? '0 : mq[0];
`else
        exp_d = m_dout;
`endif
        check_eq("level", 32'(level), 32'(n));
        check_eq("empty", 32'(empty), 32'(n == 0));
        check_eq("full", 32'(full), 32'(n == DP));
        check_eq("almost_full", 32'(almost_full), 32'(n >= 14));
        check_eq("almost_empty", 32'(almost_empty), 32'(n <= 2));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("underflow", 32'(underflow), 32'(m_udf));
        check_eq("data_out", 32'(data_out), 32'(exp_d));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1, 0, '0, 0, 0);
    endtask

    task automatic push(input logic [DW-1:0] d);
        cyc(1, 1, d, 0, 0);
    endtask

    task automatic pop(input int k);
        for (int i = 0; i < k; i++) cyc(1, 0, '0, 1, 0);
    endtask

    initial begin
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dout = '0;

        // Reset held two cycles, then idle.
        cyc(0, 0, '0, 0, 0);
        cyc(0, 0, '0, 0, 0);
        idle(2);

        // Fill 0x00..0x0F, then drain in order.
        for (int i = 0; i < DP; i++) push(DW'(i));
        idle(1);
        pop(DP);
        idle(1);

        // Overflow: write 0xAA while full, hold, clear, drain.
        for (int i = 0; i < DP; i++) push(DW'(i + 32));
        push(8'hAA);
        idle(2);
        cyc(1, 0, '0, 0, 1);
        pop(DP);

        // Simultaneous read/write at level 5.
        for (int i = 0; i < 5; i++) push(DW'($urandom_range(0, 255)));
        for (int i = 0; i < 10; i++)
            cyc(1, 1, DW'($urandom_range(0, 255)), 1, 0);
        pop(5);

        // Read+write while empty: write only, underflow sets.
        cyc(1, 1, 8'h33, 1, 0);
        pop(1);
        // Set and clear in the same cycle: set wins.
        cyc(1, 0, '0, 1, 1);
        cyc(1, 0, '0, 0, 1);

        // Wrap-around with incrementing data.
        for (int i = 0; i < 40; i++) begin
            push(DW'(i + 64));
            pop(1);
        end

        // Reset at level 9 discards contents.
        for (int i = 0; i < 9; i++) push(DW'(i + 128));
        cyc(0, 0, '0, 0, 0);
        pop(3);
        cyc(1, 0, '0, 0, 1);

        // Single word to empty FIFO, observe without reading, then pop.
        push(8'h5C);
        idle(2);
        pop(1);

        // Random traffic with phases biased toward fill and drain.
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 120; i++) begin
                bit w;
                bit r;
                bit c;
                bit rn;
                w  = ($urandom_range(0, 9) < ((ph % 2 == 0) ? 8 : 3));
                r  = ($urandom_range(0, 9) < ((ph % 2 == 0) ? 3 : 8));
                c  = ($urandom_range(0, 15) == 0);
                rn = ($urandom_range(0, 99) != 0);
                cyc(rn, w, DW'($urandom_range(0, 255)), r, c);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
